// File: rtl/mult_pkg.sv
// Shared types and constants for the radix-16 sequential multiplier.
package mult_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned NMULT   = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUILD = 2'd1,
    ACCUM = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mult_radix16_seq_if.sv
// Request/response bundle between the multiply unit and this controller.
interface mult_radix16_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mux16to1_w.sv
// Combinational 16-to-1 selector over W-bit entries.
module mux16to1_w
  import mult_pkg::*;
#(
  parameter int unsigned W = 36
) (
  input  logic [W-1:0]       din [NMULT],
  input  logic [DIGIT_W-1:0] sel,
  output logic [W-1:0]       dout_c
);

  assign dout_c = din[sel];

endmodule

// File: rtl/mult_radix16_seq.sv
// Unsigned radix-16 sequential multiplier: builds 0..15*A, then accumulates
// one shifted multiple per 4-bit digit of B with fixed latency.
module mult_radix16_seq
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mult_radix16_seq_if.slave    bus
);

  localparam int unsigned NDIG = WIDTH / DIGIT_W;
  localparam int unsigned TW   = WIDTH + DIGIT_W;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t               state;
  state_t               state_n;
  logic                 accept_c;

  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [TW-1:0]        tbl [NMULT];
  logic [3:0]           k;
  logic [IW-1:0]        i;
  logic [PW-1:0]        product_q;
  logic                 busy_q;
  logic                 done_q;

  logic [DIGIT_W-1:0]   digit_c;
  logic [TW-1:0]        mult_sel_c;
  logic [TW-1:0]        build_sum_c;
  logic [PW-1:0]        accum_sum_c;

  assign digit_c     = b_q[{i, 2'b00} +: DIGIT_W];
  assign build_sum_c = tbl[k - 4'd1] + TW'(a_q);
  // Upper bits shifted out are always zero, so the truncation is exact.
  assign accum_sum_c = product_q + (PW'(mult_sel_c) << {i, 2'b00});

  mux16to1_w #(.W(TW)) u_mux (
    .din    (tbl),
    .sel    (digit_c),
    .dout_c (mult_sel_c)
  );

  // Next-state and accept decode.
  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_n  = BUILD;
        end
      end
      BUILD: begin
        if (k == 4'(NMULT - 1)) state_n = ACCUM;
      end
      ACCUM: begin
        if (i == IW'(NDIG - 1)) state_n = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept_c = 1'b1;
          state_n  = BUILD;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, multiples table and accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      k         <= '0;
      i         <= '0;
      product_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int j = 0; j < NMULT; j++) tbl[j] <= '0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n == BUILD) || (state_n == ACCUM);
      done_q <= (state_n == DONE);
      if (accept_c) begin
        a_q       <= bus.a;
        b_q       <= bus.b;
        tbl[0]    <= '0;
        tbl[1]    <= TW'(bus.a);
        k         <= 4'd2;
        i         <= '0;
        product_q <= '0;
      end
      if (state == BUILD) begin
        tbl[k] <= build_sum_c;
        k      <= k + 4'd1;
      end
      if (state == ACCUM) begin
        product_q <= accum_sum_c;
        i         <= i + IW'(1);
      end
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;

endmodule

// File: tb/tb_mult_radix16_seq.sv
// Scoreboard bench for mult_radix16_seq: directed cases plus random operands
// with random issue gaps, checked against plain 64-bit multiplication.
module tb_mult_radix16_seq;

  localparam int unsigned WIDTH = 32;
  localparam int LAT = 22;  // edges from the accepting edge to the edge that raises done

  typedef struct {
    logic [63:0] prod;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_radix16_seq_if #(.WIDTH(WIDTH)) bus ();

  mult_radix16_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t        q[$];
  int          cyc       = 0;
  int          last_acc  = -1000;
  int          kill_edge = 0;
  int          ntests    = 0;
  int          nfail     = 0;
  bit          mon_en    = 1'b0;
  bit          held      = 1'b0;
  logic [63:0] held_val  = '0;
  int          held_cyc  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  function automatic bit killed();
    return kill_edge > last_acc;
  endfunction

  // Monitor: busy window, done timing, product value and product hold.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   exp_busy;
      bit   exp_done;
      exp_t ent;
      exp_busy = (cyc >= last_acc) && (cyc <= last_acc + LAT - 1) &&
                 !(killed() && cyc >= kill_edge);
      check("busy", 64'(bus.busy), 64'(exp_busy));
      exp_done = (q.size() > 0) && (q[0].due == cyc);
      check("done", 64'(bus.done), 64'(exp_done));
      if (exp_done) begin
        ent = q.pop_front();
        check("product", bus.product, ent.prod);
        held     = 1'b1;
        held_val = ent.prod;
        held_cyc = cyc;
      end else begin
        while (q.size() > 0 && q[0].due < cyc) void'(q.pop_front());
        if (held && !(last_acc > held_cyc && cyc >= last_acc) &&
            !(kill_edge > held_cyc && cyc >= kill_edge))
          check("product_hold", bus.product, held_val);
      end
    end
  end

  task automatic issue(input logic [31:0] av, input logic [31:0] bv);
    int   e;
    exp_t ent;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    e = cyc + 1;
    if (killed() || e >= last_acc + LAT + 1) begin
      last_acc = e;
      ent.prod = 64'(av) * 64'(bv);
      ent.due  = e + LAT;
      q.push_back(ent);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = $urandom;
    bus.b     = $urandom;
  endtask

  task automatic apply_reset(input bit with_start);
    @(negedge clk);
    rst       = 1'b1;
    bus.start = with_start;
    kill_edge = cyc + 1;
    while (q.size() > 0 && q[$].due >= kill_edge) void'(q.pop_back());
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ntests++;
    if (q.size() > 0) begin
      nfail++;
      $display("FAIL done_timeout at cycle %0d: got %0d pending, expected 0", cyc, q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    kill_edge = cyc;
    mon_en    = 1'b1;
    check("reset_product", bus.product, 64'h0);
    repeat (6) @(negedge clk);

    issue(32'd3, 32'd5);
    wait_idle();
    check("small_result", bus.product, 64'h0000_0000_0000_000F);

    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle();

    // Start while busy is ignored.
    issue(32'd7, 32'hFFFF_FFFF);
    repeat (3) @(negedge clk);
    issue(32'd1, 32'd1);
    wait_idle();
    check("ignored_start_result", bus.product, 64'h0000_0006_FFFF_FFF9);

    // Back-to-back: second start driven in the DONE cycle.
    issue(32'h0001_0000, 32'h0001_0000);
    while (cyc < last_acc + LAT - 1) @(negedge clk);
    issue(32'd0, 32'h1234);
    wait_idle();

    // Abort mid-operation, then a fresh operation.
    issue(32'd9, 32'd9);
    repeat (9) @(negedge clk);
    apply_reset(1'b0);
    check("abort_product", bus.product, 64'h0);
    issue(32'd2, 32'd3);
    wait_idle();

    // Reset and start together: reset wins.
    apply_reset(1'b1);
    repeat (4) @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: ra = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'hFFFF_FFFF;
        default: ;
      endcase
      repeat ($urandom_range(0, 25)) @(negedge clk);
      issue(ra, rb);
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
